alu_pipe: RTL and testbench
===========================

# alu_pipe

Pipelined, parametrised integer execution unit for the Tomasulo core. It accepts one ready-operand operation per cycle from the ALU reservation station and computes the RV32I ALU, jump and branch result. Results are buffered in an in-order result FIFO, which presents them to the common data bus (CDB) under a grant handshake. All in-flight and buffered work is discarded on a ROB flush.

## Interface
- XLEN, 32, datapath width.
- ROB_W, 4, ROB index width.
- DEPTH, 4, result FIFO entries; a power of two, at least 2.
- OPT_W, 6, opcode width; encodings are the shared `utils.v` opcode defines.

- clk_in  in  1  clock
- rst_n_in  in  1  reset; asynchronous, active-low
- rdy_in  in  1  global enable; when low, all state is frozen
- flush_in  in  1  ROB misprediction flush
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept the operation
- in_opt  in  OPT_W  opcode
- in_rs1, in_rs2, in_imm, in_pc  in  XLEN each  operands
- in_rob  in  ROB_W  destination ROB index
- out_valid  out  1  FIFO head valid toward the CDB
- out_grant  in  1  CDB consumed the head this cycle
- out_res  out  XLEN  rd value
- out_rob  out  ROB_W  ROB index
- out_jump  out  1  branch taken, or JAL/JALR
- out_pc  out  XLEN  jump target; 0 when out_jump=0

## Operation
- Accept occurs when in_valid && in_ready && rdy_in && !flush_in.
- Compute stage (S1) registers the result.
- Write into the FIFO occurs when S1 is valid.
- in_ready = (fifo_count + inflight) < DEPTH, where inflight is the number of valid compute stages. The FIFO never overflows, and results never need back-pressure inside the pipe.
- Results per opcode:
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL: res=pc+4, pc=pc+imm, jump=1.
  - JALR: res=pc+4, pc=(rs1+imm)&~1, jump=1.
  - Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU): res=0; jump and pc=pc+imm only when the condition holds. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - Immediate and register arithmetic/logic: standard RV32I semantics.
- Shift rules:
  - Shift amount is operand[4:0]; upper bits are ignored.
  - SRA/SRAI are arithmetic.
  - SLT/SLTU produce a 1-bit result, zero-extended.
- Undefined opcode: res=0, jump=0. The result is still written, so the ROB entry completes.
- All arithmetic wraps modulo 2^XLEN.
- FIFO is strictly in-order. The head pops when out_valid && out_grant && rdy_in.
- If the FIFO is full and has a pending write in the same cycle, the write is legal only with a simultaneous pop; the in_ready rule guarantees the case never arises otherwise.
- Simultaneous push and pop: count is unchanged, pointers wrap modulo DEPTH.
- flush_in (sampled only when rdy_in=1):
  - Clears all stage valids and the FIFO; pointers and count go to 0.
  - Overrides a same-cycle accept, push and pop.
  - out_grant in the flush cycle is ignored.
- rdy_in=0: nothing accepted, pushed, popped or flushed; outputs hold.

## Timing
- Reset state: in_ready=1, out_valid=0, out_res=0, out_rob=0, out_jump=0, out_pc=0, FIFO empty. Reset takes effect immediately, mid-operation included, with no partial results retained.
- Latency from accept at edge N, without the macro: FIFO write at edge N+1, out_valid=1 after edge N+1.
- Throughput: one operation per cycle while in_ready=1.
- out_* are driven from the FIFO head register; there is no combinational path from in_* to out_*.
- in_ready depends only on registered state, not on in_valid or out_grant.
- After a flush at edge F: out_valid=0 and in_ready=1 after F.

## Configuration
- ALU_MUL_EN defined:
  - Adds the MUL, MULH, MULHSU and MULHU opcodes, which produce the low/high product words with RV32M sign rules.
  - Adds a second compute stage S2 for all operations, preserving order. Latency becomes edge N+2, and inflight counts S1 and S2.
- ALU_MUL_EN undefined:
  - Single compute stage.
  - MUL* opcodes are treated as undefined (res=0).
  - No multiplier hardware.

## Test plan
- Reset, then ADDI rs1=5, imm=-3, rob=2 -> one cycle later out_valid=1, out_res=2, out_rob=2, out_jump=0.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> out_jump=1, out_pc=0x120. The same operands with BLTU -> out_jump=0, out_pc=0.
- JALR rs1=0x1003, imm=2, pc=0x40 -> out_res=0x44, out_pc=0x1004, out_jump=1. SRA rs1=0x80000000, rs2=0x21 -> out_res=0xC0000000.
- out_grant held low while 4 ADDs are issued (DEPTH=4) -> in_ready=0 after the 4th accept. Then one grant -> in_ready=1 next cycle, and results pop in issue order across pointer wrap.
- 3 results buffered, with an accept and flush_in in the same cycle -> after the edge out_valid=0, in_ready=1, and no stale result ever appears.
- With ALU_MUL_EN: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE at N+2. Issuing MUL then ADD back-to-back -> results emerge in order.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: issue-side and CDB-side handshake bundle for the ALU execution unit.
// The master modport is the reservation station / CDB side, the slave modport is the unit.
interface alu_pipe_if #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4,
    parameter int OPT_W = 6
);
    // Issue from the reservation station
    logic             in_valid;
    logic             in_ready;
    logic [OPT_W-1:0] in_opt;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_pc;
    logic [ROB_W-1:0] in_rob;

    // Result toward the common data bus
    logic             out_valid;
    logic             out_grant;
    logic [XLEN-1:0]  out_res;
    logic [ROB_W-1:0] out_rob;
    logic             out_jump;
    logic [XLEN-1:0]  out_pc;

    modport master (
        output in_valid, in_opt, in_rs1, in_rs2, in_imm, in_pc, in_rob, out_grant,
        input  in_ready, out_valid, out_res, out_rob, out_jump, out_pc
    );

    modport slave (
        input  in_valid, in_opt, in_rs1, in_rs2, in_imm, in_pc, in_rob, out_grant,
        output in_ready, out_valid, out_res, out_rob, out_jump, out_pc
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined RV32I ALU / jump / branch execution unit with an in-order
// result FIFO feeding the CDB. Define ALU_MUL_EN to add MUL/MULH/MULHSU/MULHU
// and a second compute stage (two-cycle latency to the FIFO).
module alu_pipe #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4,
    parameter int DEPTH = 4,
    parameter int OPT_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    alu_pipe_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam int EW = XLEN + ROB_W + 1 + XLEN;

    localparam logic [OPT_W-1:0] OP_LUI   = OPT_W'(1);
    localparam logic [OPT_W-1:0] OP_AUIPC = OPT_W'(2);
    localparam logic [OPT_W-1:0] OP_JAL   = OPT_W'(3);
    localparam logic [OPT_W-1:0] OP_JALR  = OPT_W'(4);
    localparam logic [OPT_W-1:0] OP_BEQ   = OPT_W'(5);
    localparam logic [OPT_W-1:0] OP_BNE   = OPT_W'(6);
    localparam logic [OPT_W-1:0] OP_BLT   = OPT_W'(7);
    localparam logic [OPT_W-1:0] OP_BGE   = OPT_W'(8);
    localparam logic [OPT_W-1:0] OP_BLTU  = OPT_W'(9);
    localparam logic [OPT_W-1:0] OP_BGEU  = OPT_W'(10);
    localparam logic [OPT_W-1:0] OP_ADDI  = OPT_W'(11);
    localparam logic [OPT_W-1:0] OP_SLTI  = OPT_W'(12);
    localparam logic [OPT_W-1:0] OP_SLTIU = OPT_W'(13);
    localparam logic [OPT_W-1:0] OP_XORI  = OPT_W'(14);
    localparam logic [OPT_W-1:0] OP_ORI   = OPT_W'(15);
    localparam logic [OPT_W-1:0] OP_ANDI  = OPT_W'(16);
    localparam logic [OPT_W-1:0] OP_SLLI  = OPT_W'(17);
    localparam logic [OPT_W-1:0] OP_SRLI  = OPT_W'(18);
    localparam logic [OPT_W-1:0] OP_SRAI  = OPT_W'(19);
    localparam logic [OPT_W-1:0] OP_ADD   = OPT_W'(20);
    localparam logic [OPT_W-1:0] OP_SUB   = OPT_W'(21);
    localparam logic [OPT_W-1:0] OP_SLL   = OPT_W'(22);
    localparam logic [OPT_W-1:0] OP_SLT   = OPT_W'(23);
    localparam logic [OPT_W-1:0] OP_SLTU  = OPT_W'(24);
    localparam logic [OPT_W-1:0] OP_XOR   = OPT_W'(25);
    localparam logic [OPT_W-1:0] OP_SRL   = OPT_W'(26);
    localparam logic [OPT_W-1:0] OP_SRA   = OPT_W'(27);
    localparam logic [OPT_W-1:0] OP_OR    = OPT_W'(28);
    localparam logic [OPT_W-1:0] OP_AND   = OPT_W'(29);
`ifdef ALU_MUL_EN
    localparam logic [OPT_W-1:0] OP_MUL    = OPT_W'(30);
    localparam logic [OPT_W-1:0] OP_MULH   = OPT_W'(31);
    localparam logic [OPT_W-1:0] OP_MULHSU = OPT_W'(32);
    localparam logic [OPT_W-1:0] OP_MULHU  = OPT_W'(33);
`endif

    // ---------------- operand helpers ----------------
    logic [XLEN-1:0] rs1, rs2, imm, pc;
    logic [XLEN-1:0] pc_imm, pc_4, jalr_sum, jalr_tgt, sra_r, sra_i;
    logic [4:0]      sh_r, sh_i;
    logic            rs_eq, rs_lt_s, rs_lt_u, ri_lt_s, ri_lt_u;

    assign rs1      = bus.in_rs1;
    assign rs2      = bus.in_rs2;
    assign imm      = bus.in_imm;
    assign pc       = bus.in_pc;
    assign sh_r     = rs2[4:0];
    assign sh_i     = imm[4:0];
    assign pc_imm   = pc + imm;
    assign pc_4     = pc + XLEN'(4);
    assign jalr_sum = rs1 + imm;
    assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
    assign sra_r    = XLEN'($signed(rs1) >>> sh_r);
    assign sra_i    = XLEN'($signed(rs1) >>> sh_i);
    assign rs_eq    = (rs1 == rs2);
    assign rs_lt_s  = ($signed(rs1) < $signed(rs2));
    assign rs_lt_u  = (rs1 < rs2);
    assign ri_lt_s  = ($signed(rs1) < $signed(imm));
    assign ri_lt_u  = (rs1 < imm);

    logic [XLEN-1:0] alu_res, alu_pc;
    logic            alu_jump, br_take;

    // Per-opcode ALU, jump and branch result; undefined opcodes yield zeros
    always_comb begin
        alu_res  = '0;
        alu_pc   = '0;
        alu_jump = 1'b0;
        br_take  = 1'b0;
        case (bus.in_opt)
            OP_LUI:   alu_res = imm;
            OP_AUIPC: alu_res = pc_imm;
            OP_JAL:   begin alu_res = pc_4; alu_jump = 1'b1; alu_pc = pc_imm;   end
            OP_JALR:  begin alu_res = pc_4; alu_jump = 1'b1; alu_pc = jalr_tgt; end
            OP_BEQ:   br_take = rs_eq;
            OP_BNE:   br_take = !rs_eq;
            OP_BLT:   br_take = rs_lt_s;
            OP_BGE:   br_take = !rs_lt_s;
            OP_BLTU:  br_take = rs_lt_u;
            OP_BGEU:  br_take = !rs_lt_u;
            OP_ADDI:  alu_res = rs1 + imm;
            OP_SLTI:  alu_res = {{(XLEN-1){1'b0}}, ri_lt_s};
            OP_SLTIU: alu_res = {{(XLEN-1){1'b0}}, ri_lt_u};
            OP_XORI:  alu_res = rs1 ^ imm;
            OP_ORI:   alu_res = rs1 | imm;
            OP_ANDI:  alu_res = rs1 & imm;
            OP_SLLI:  alu_res = rs1 << sh_i;
            OP_SRLI:  alu_res = rs1 >> sh_i;
            OP_SRAI:  alu_res = sra_i;
            OP_ADD:   alu_res = rs1 + rs2;
            OP_SUB:   alu_res = rs1 - rs2;
            OP_SLL:   alu_res = rs1 << sh_r;
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, rs_lt_s};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, rs_lt_u};
            OP_XOR:   alu_res = rs1 ^ rs2;
            OP_SRL:   alu_res = rs1 >> sh_r;
            OP_SRA:   alu_res = sra_r;
            OP_OR:    alu_res = rs1 | rs2;
            OP_AND:   alu_res = rs1 & rs2;
            default:  ;
        endcase
        if (br_take) begin
            alu_jump = 1'b1;
            alu_pc   = pc_imm;
        end
    end

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {MUL_NONE, MUL_LO, MUL_HI} mul_sel_t;

    mul_sel_t          mul_sel;
    logic              mul_a_s, mul_b_s;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;

    // Multiply decode: which product half, and signedness of each operand
    always_comb begin
        mul_sel = MUL_NONE;
        mul_a_s = 1'b0;
        mul_b_s = 1'b0;
        case (bus.in_opt)
            OP_MUL:    mul_sel = MUL_LO;
            OP_MULH:   begin mul_sel = MUL_HI; mul_a_s = 1'b1; mul_b_s = 1'b1; end
            OP_MULHSU: begin mul_sel = MUL_HI; mul_a_s = 1'b1; end
            OP_MULHU:  mul_sel = MUL_HI;
            default:   ;
        endcase
    end

    // Sign- or zero-extend to double width so one unsigned multiply covers all variants
    assign mul_a    = {{XLEN{mul_a_s & rs1[XLEN-1]}}, rs1};
    assign mul_b    = {{XLEN{mul_b_s & rs2[XLEN-1]}}, rs2};
    assign mul_prod = mul_a * mul_b;
`endif

    // ---------------- pipeline control ----------------
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [CW-1:0] occupancy;
    logic          in_ready_int, out_valid_int, accept, push, pop;

    logic             s1_valid_reg, s1_jump_reg;
    logic [XLEN-1:0]  s1_res_reg, s1_pc_reg;
    logic [ROB_W-1:0] s1_rob_reg;

    logic             last_valid, last_jump;
    logic [XLEN-1:0]  last_res, last_pc;
    logic [ROB_W-1:0] last_rob;

    assign accept        = bus.in_valid && in_ready_int && rdy_in && !flush_in;
    assign out_valid_int = (count_reg != '0);
    assign push          = last_valid && rdy_in && !flush_in;
    assign pop           = out_valid_int && bus.out_grant && rdy_in && !flush_in;

    // S1 valid: a flush or stall-free cycle without accept empties the stage
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   s1_valid_reg <= 1'b0;
        else if (rdy_in) s1_valid_reg <= accept;
    end

    // S1 data: capture the computed result on accept
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_res_reg  <= '0;
            s1_pc_reg   <= '0;
            s1_jump_reg <= 1'b0;
            s1_rob_reg  <= '0;
        end else if (accept) begin
            s1_res_reg  <= alu_res;
            s1_pc_reg   <= alu_pc;
            s1_jump_reg <= alu_jump;
            s1_rob_reg  <= bus.in_rob;
        end
    end

`ifdef ALU_MUL_EN
    mul_sel_t          s1_mul_sel_reg;
    logic [2*XLEN-1:0] s1_prod_reg;
    logic              s2_valid_reg, s2_jump_reg;
    logic [XLEN-1:0]   s2_res_reg, s2_pc_reg;
    logic [ROB_W-1:0]  s2_rob_reg;

    // S1 product: registered full-width product and the half to select in S2
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_mul_sel_reg <= MUL_NONE;
            s1_prod_reg    <= '0;
        end else if (accept) begin
            s1_mul_sel_reg <= mul_sel;
            s1_prod_reg    <= mul_prod;
        end
    end

    // S2 valid: follows S1 one cycle later, cleared by flush
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   s2_valid_reg <= 1'b0;
        else if (rdy_in) s2_valid_reg <= s1_valid_reg && !flush_in;
    end

    // S2 data: final result, multiply half substituted where selected
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_res_reg  <= '0;
            s2_pc_reg   <= '0;
            s2_jump_reg <= 1'b0;
            s2_rob_reg  <= '0;
        end else if (rdy_in && s1_valid_reg) begin
            case (s1_mul_sel_reg)
                MUL_LO:  s2_res_reg <= s1_prod_reg[XLEN-1:0];
                MUL_HI:  s2_res_reg <= s1_prod_reg[2*XLEN-1:XLEN];
                default: s2_res_reg <= s1_res_reg;
            endcase
            s2_pc_reg   <= s1_pc_reg;
            s2_jump_reg <= s1_jump_reg;
            s2_rob_reg  <= s1_rob_reg;
        end
    end

    assign last_valid = s2_valid_reg;
    assign last_res   = s2_res_reg;
    assign last_pc    = s2_pc_reg;
    assign last_jump  = s2_jump_reg;
    assign last_rob   = s2_rob_reg;
    assign occupancy  = CW'(count_reg) + CW'(s1_valid_reg) + CW'(s2_valid_reg);
`else
    assign last_valid = s1_valid_reg;
    assign last_res   = s1_res_reg;
    assign last_pc    = s1_pc_reg;
    assign last_jump  = s1_jump_reg;
    assign last_rob   = s1_rob_reg;
    assign occupancy  = CW'(count_reg) + CW'(s1_valid_reg);
`endif

    // Reserving FIFO space for in-flight work means the pipe never needs back-pressure
    assign in_ready_int = (occupancy < CW'(DEPTH));

    // ---------------- result FIFO ----------------
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [EW-1:0] head;

    // Entry storage; stale contents are masked by out_valid so no reset is needed
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr_reg] <= {last_res, last_rob, last_jump, last_pc};
    end

    // Pointers and count; flush empties the FIFO and overrides push/pop
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                if (push && !pop)      count_reg <= count_reg + (AW+1)'(1);
                else if (pop && !push) count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

    assign head = fifo_mem[rd_ptr_reg];

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_res   = out_valid_int ? head[EW-1 -: XLEN]          : '0;
    assign bus.out_rob   = out_valid_int ? head[XLEN+1 +: ROB_W]       : '0;
    assign bus.out_jump  = out_valid_int ? head[XLEN]                  : 1'b0;
    assign bus.out_pc    = out_valid_int ? head[XLEN-1:0]              : '0;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a transaction-level
// reference model (an in-order queue of expected results with per-entry age).
module tb_alu_pipe;
    localparam int DEPTH = 4;
`ifdef ALU_MUL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [5:0] OP_LUI = 1, OP_AUIPC = 2, OP_JAL = 3, OP_JALR = 4;
    localparam logic [5:0] OP_BEQ = 5, OP_BNE = 6, OP_BLT = 7, OP_BGE = 8, OP_BLTU = 9, OP_BGEU = 10;
    localparam logic [5:0] OP_ADDI = 11, OP_SLTI = 12, OP_SLTIU = 13, OP_XORI = 14, OP_ORI = 15;
    localparam logic [5:0] OP_ANDI = 16, OP_SLLI = 17, OP_SRLI = 18, OP_SRAI = 19;
    localparam logic [5:0] OP_ADD = 20, OP_SUB = 21, OP_SLL = 22, OP_SLT = 23, OP_SLTU = 24;
    localparam logic [5:0] OP_XOR = 25, OP_SRL = 26, OP_SRA = 27, OP_OR = 28, OP_AND = 29;
    localparam logic [5:0] OP_MUL = 30, OP_MULH = 31, OP_MULHSU = 32, OP_MULHU = 33;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  rob;
        logic        jump;
        logic [31:0] pc;
        int          age;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic flush = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_pipe_if #(.XLEN(32), .ROB_W(4), .OPT_W(6)) ifc ();

    alu_pipe #(.XLEN(32), .ROB_W(4), .DEPTH(DEPTH), .OPT_W(6)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (ifc.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Signed compare done by biasing both operands, unsigned arithmetic otherwise
    function automatic logic lt_signed(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] sra(input logic [31:0] a, input logic [4:0] sh);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        m = m >> sh;
        return (a >> sh) | (a[31] ? ~m : 32'h0);
    endfunction

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        exp_t e;
        logic taken;
        logic [63:0] p;
        longint sp;
        e.res = 0; e.rob = rob; e.jump = 0; e.pc = 0; e.age = 0;
        taken = 0;
        p = 0;
        sp = 0;
        case (op)
            OP_LUI:   e.res = imm;
            OP_AUIPC: e.res = pc + imm;
            OP_JAL:   begin e.res = pc + 4; e.jump = 1; e.pc = pc + imm; end
            OP_JALR:  begin e.res = pc + 4; e.jump = 1; e.pc = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ:   taken = (a == b);
            OP_BNE:   taken = (a != b);
            OP_BLT:   taken = lt_signed(a, b);
            OP_BGE:   taken = !lt_signed(a, b);
            OP_BLTU:  taken = (a < b);
            OP_BGEU:  taken = (a >= b);
            OP_ADDI:  e.res = a + imm;
            OP_SLTI:  e.res = {31'b0, lt_signed(a, imm)};
            OP_SLTIU: e.res = {31'b0, a < imm};
            OP_XORI:  e.res = a ^ imm;
            OP_ORI:   e.res = a | imm;
            OP_ANDI:  e.res = a & imm;
            OP_SLLI:  e.res = a << imm[4:0];
            OP_SRLI:  e.res = a >> imm[4:0];
            OP_SRAI:  e.res = sra(a, imm[4:0]);
            OP_ADD:   e.res = a + b;
            OP_SUB:   e.res = a - b;
            OP_SLL:   e.res = a << b[4:0];
            OP_SLT:   e.res = {31'b0, lt_signed(a, b)};
            OP_SLTU:  e.res = {31'b0, a < b};
            OP_XOR:   e.res = a ^ b;
            OP_SRL:   e.res = a >> b[4:0];
            OP_SRA:   e.res = sra(a, b[4:0]);
            OP_OR:    e.res = a | b;
            OP_AND:   e.res = a & b;
`ifdef ALU_MUL_EN
            OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; end
            OP_MULH:   begin sp = longint'($signed(a)) * longint'($signed(b)); p = sp; e.res = p[63:32]; end
            OP_MULHSU: begin sp = longint'($signed(a)) * longint'({32'b0, b}); p = sp; e.res = p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; end
`endif
            default: ;
        endcase
        if (taken) begin
            e.jump = 1;
            e.pc = pc + imm;
        end
        return e;
    endfunction

    // One clock: check DUT against the model, then advance the model across the edge
    task automatic step();
        logic exp_ov, acc, pop;
        exp_t e;
        #1;
        exp_ov = (exp_q.size() > 0) && (exp_q[0].age >= LAT);
        chk("out_valid", ifc.out_valid, exp_ov);
        chk("in_ready", ifc.in_ready, exp_q.size() < DEPTH);
        if (exp_ov) begin
            chk("head.res", ifc.out_res, exp_q[0].res);
            chk("head.rob", ifc.out_rob, exp_q[0].rob);
            chk("head.jump", ifc.out_jump, exp_q[0].jump);
            chk("head.pc", ifc.out_pc, exp_q[0].pc);
        end
        acc = ifc.in_valid && (exp_q.size() < DEPTH) && rdy && !flush;
        pop = exp_ov && ifc.out_grant && rdy && !flush;
        e = model(ifc.in_opt, ifc.in_rs1, ifc.in_rs2, ifc.in_imm, ifc.in_pc, ifc.in_rob);
        @(posedge clk);
        if (rdy) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (pop) exp_q.pop_front();
                foreach (exp_q[i]) exp_q[i].age++;
                if (acc) exp_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic set_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        ifc.in_opt = op; ifc.in_rs1 = a; ifc.in_rs2 = b; ifc.in_imm = imm; ifc.in_pc = pc; ifc.in_rob = rob;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        set_op(op, a, b, imm, pc, rob);
        ifc.in_valid = 1'b1;
        step();
        ifc.in_valid = 1'b0;
    endtask

    // Compare the visible head against hand-derived constants, then pop it
    task automatic expect_head(input string tag, input logic [31:0] res, input logic [3:0] rob,
                               input logic jump, input logic [31:0] pc);
        chk({tag, ".valid"}, ifc.out_valid, 1'b1);
        chk({tag, ".res"}, ifc.out_res, res);
        chk({tag, ".rob"}, ifc.out_rob, rob);
        chk({tag, ".jump"}, ifc.out_jump, jump);
        chk({tag, ".pc"}, ifc.out_pc, pc);
        ifc.out_grant = 1'b1;
        step();
        ifc.out_grant = 1'b0;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom_range(0, 40);
            2:       return 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: return 32'h8000_0000;
        endcase
    endfunction

    initial begin
        ifc.in_valid = 1'b0;
        ifc.out_grant = 1'b0;
        set_op(0, 0, 0, 0, 0, 0);

        // Reset state
        #22;
        chk("rst.out_valid", ifc.out_valid, 1'b0);
        chk("rst.in_ready", ifc.in_ready, 1'b1);
        chk("rst.out_res", ifc.out_res, 32'h0);
        chk("rst.out_rob", ifc.out_rob, 4'h0);
        chk("rst.out_jump", ifc.out_jump, 1'b0);
        chk("rst.out_pc", ifc.out_pc, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operations from the test plan
        issue(OP_ADDI, 5, 0, 32'hFFFF_FFFD, 0, 2);
        repeat (LAT) step();
        expect_head("addi", 32'h2, 4'h2, 1'b0, 32'h0);
        issue(OP_BLT, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 3);
        repeat (LAT) step();
        expect_head("blt", 32'h0, 4'h3, 1'b1, 32'h120);
        issue(OP_BLTU, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 4);
        repeat (LAT) step();
        expect_head("bltu", 32'h0, 4'h4, 1'b0, 32'h0);
        issue(OP_JALR, 32'h1003, 0, 2, 32'h40, 5);
        repeat (LAT) step();
        expect_head("jalr", 32'h44, 4'h5, 1'b1, 32'h1004);
        issue(OP_SRA, 32'h8000_0000, 32'h21, 0, 0, 6);
        repeat (LAT) step();
        expect_head("sra", 32'hC000_0000, 4'h6, 1'b0, 32'h0);
        issue(6'd63, 32'h1234, 32'h5678, 32'h9, 32'h80, 7);
        repeat (LAT) step();
        expect_head("undef", 32'h0, 4'h7, 1'b0, 32'h0);

        // rdy_in low freezes everything, grant included
        issue(OP_ADD, 10, 20, 0, 0, 8);
        rdy = 1'b0;
        ifc.out_grant = 1'b1;
        ifc.in_valid = 1'b1;
        repeat (3) step();
        ifc.in_valid = 1'b0;
        ifc.out_grant = 1'b0;
        rdy = 1'b1;
        repeat (LAT) step();
        expect_head("frozen", 32'd30, 4'h8, 1'b0, 32'h0);

        // Fill the FIFO with grant low, then one grant reopens in_ready; pointers wrap
        ifc.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(OP_ADD, 32'(100 * k), 32'(k), 0, 0, 4'(k + 9));
            step();
        end
        ifc.in_valid = 1'b0;
        chk("full.in_ready", ifc.in_ready, 1'b0);
        repeat (LAT) step();
        chk("full.in_ready_hold", ifc.in_ready, 1'b0);
        ifc.out_grant = 1'b1;
        step();
        ifc.out_grant = 1'b0;
        chk("grant.in_ready", ifc.in_ready, 1'b1);
        ifc.out_grant = 1'b1;
        repeat (5) step();

        // Flush with three buffered results and a same-cycle accept
        ifc.out_grant = 1'b0;
        for (int k = 0; k < 3; k++) issue(OP_ADD, 32'(k), 1, 0, 0, 4'(k));
        repeat (LAT) step();
        set_op(OP_ADD, 7, 7, 0, 0, 1);
        ifc.in_valid = 1'b1;
        ifc.out_grant = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        chk("flush.out_valid", ifc.out_valid, 1'b0);
        chk("flush.in_ready", ifc.in_ready, 1'b1);
        repeat (4) step();

        // Multiply results, or zero when multiply support is absent
        ifc.out_grant = 1'b0;
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 3);
        repeat (LAT) step();
`ifdef ALU_MUL_EN
        expect_head("mulhu", 32'hFFFF_FFFE, 4'h3, 1'b0, 32'h0);
`else
        expect_head("mulhu", 32'h0, 4'h3, 1'b0, 32'h0);
`endif
        ifc.in_valid = 1'b1;
        set_op(OP_MUL, 32'h1_0001, 32'h3, 0, 0, 1);
        step();
        set_op(OP_ADD, 32'h5, 32'h6, 0, 0, 2);
        step();
        ifc.in_valid = 1'b0;
        ifc.out_grant = 1'b1;
        repeat (4) step();

        // Asynchronous reset mid-operation discards everything at once
        ifc.out_grant = 1'b0;
        issue(OP_ADD, 1, 2, 0, 0, 1);
        issue(OP_ADD, 3, 4, 0, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", ifc.out_valid, 1'b0);
        chk("arst.in_ready", ifc.in_ready, 1'b1);
        chk("arst.out_res", ifc.out_res, 32'h0);
        exp_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) step();

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            set_op(6'($urandom_range(0, 35)), rnd_word(), rnd_word(), rnd_word(), rnd_word(), 4'($urandom));
            ifc.in_valid = ($urandom_range(0, 3) != 0);
            ifc.out_grant = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 29) == 0);
            step();
        end

        // Drain with a bounded budget
        ifc.in_valid = 1'b0;
        ifc.out_grant = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
        step();
        chk("drain.out_valid", ifc.out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
